// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU opcode sweep controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package alu_sweep_pkg;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 4;
  localparam int NUM_OPS = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Rotate the running signature left by one, then fold in the new result.
  function automatic logic [DATA_W-1:0] sig_update(input logic [DATA_W-1:0] sig,
                                                   input logic [DATA_W-1:0] data);
    return {sig[DATA_W-2:0], sig[DATA_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/alu_result_buf.sv
// Result store: one entry per opcode, written at capture, read back by the host.
// Latency: write lands on the clock edge; read is combinational (old data until the edge).
// Backpressure: none, always accepts a write and always serves a read.
module alu_result_buf
  import alu_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [OP_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [OP_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_OPS];

  // Storage array: only reset clears it, so results survive across sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Sweeps opcodes 0..NUM_OPS-1 through an external ALU for one latched operand pair.
// Latency: SETTLE+1 cycles per opcode; done pulses the cycle after the last capture.
// Backpressure: start only sampled in IDLE; abort cancels a running sweep without a done pulse.
module alu_sweep_ctrl
  import alu_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2  // hold cycles before capture, must be at least 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] signature_o,
  input  logic [OP_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(NUM_OPS - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] sig_d;
  logic              busy_q;
  logic              done_q;
  logic              capture_en;

  // An abort in the capture cycle wins, so neither buffer nor signature moves.
  assign capture_en = (state_q == ST_CAPTURE) && !abort_i;
  assign sig_d      = sig_update(sig_q, alu_out_i);

  // Sweep sequencer; busy/done are registered alongside the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      sig_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            alu_a_q  <= a_i;
            alu_b_q  <= b_i;
            alu_op_q <= '0;
            cnt_q    <= '0;
            sig_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            sig_q <= sig_d;
            if (alu_op_q == OP_LAST) begin
              // Opcode stays at the last value through DONE.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              alu_op_q <= alu_op_q + OP_W'(1);
              cnt_q    <= '0;
              state_q  <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  alu_result_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (capture_en),
    .wr_addr_i (alu_op_q),
    .wr_data_i (alu_out_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign signature_o = sig_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for the opcode sweep controller driven against a stub ALU (out = a + op).
// Latency: expected values derived per clock edge from the edge-numbered sweep timeline.
// Backpressure: exercises abort, ignored start, reset mid-sweep and start held through DONE.
module tb_alu_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 1;   // cycles per opcode
  localparam int NOPS   = 16;
  localparam int LAST_E = NOPS * P;     // edge of the final capture

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] a_in = 8'd0;
  logic [7:0] b_in = 8'd0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       busy;
  logic       done;
  logic [7:0] signature;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Reference state: what the result buffer and signature should hold.
  logic [7:0] mbuf [NOPS];
  logic [7:0] msig;

  assign alu_out = alu_a + {4'b0, alu_op};

  always #5 clk = ~clk;

  alu_sweep_ctrl #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .a_i         (a_in),
    .b_i         (b_in),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_out_i   (alu_out),
    .busy_o      (busy),
    .done_o      (done),
    .signature_o (signature),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input int k);
    return a + 8'(k);
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], s[7]} ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads every buffer entry; only call while the controller is idle.
  task automatic check_buf(input string tag);
    for (int i = 0; i < NOPS; i++) begin
      rd_addr = 4'(i);
      #1;
      check(tag, rd_data, mbuf[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, alu_a, 0);
    check({tag, "_b"}, alu_b, 0);
    check({tag, "_op"}, alu_op, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sig"}, signature, 0);
  endtask

  // One sweep with optional abort edge, ignored restart edge, reset cycle and start held high.
  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b,
                           input int abort_e, input int restart_e, input int rst_e,
                           input bit hold, input bit skip_start,
                           output logic [7:0] next_a);
    int e;
    int k;
    next_a = a;
    if (!skip_start) begin
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      tick();
    end
    start = hold;
    msig  = 8'd0;
    check("accept_busy", busy, 1);
    check("latch_a", alu_a, a);
    check("latch_b", alu_b, b);
    check("sig_clear", signature, 0);
    check("op_first", alu_op, 0);
    for (int n = 1; n <= LAST_E + 1; n++) begin
      if (n == rst_e) begin
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        for (int i = 0; i < NOPS; i++) begin
          rd_addr = 4'(i);
          #1;
          check("rst_mid_rd", rd_data, 0);
          mbuf[i] = 8'd0;
        end
        msig = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      abort   = (n == abort_e);
      start   = hold || (n == restart_e);
      a_in    = 8'($urandom);
      b_in    = 8'($urandom);
      rd_addr = 4'($urandom);
      tick();
      if (n == abort_e && n <= LAST_E) begin
        e = (n - 1) / P;
        if (e > NOPS - 1) e = NOPS - 1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_op", alu_op, e);
        check("abort_sig", signature, msig);
        check("abort_rd", rd_data, mbuf[rd_addr]);
        check("abort_a", alu_a, a);
        return;
      end
      if (n % P == 0 && n <= LAST_E) begin
        k = n / P - 1;
        mbuf[k] = ref_alu(a, k);
        msig    = fold(msig, mbuf[k]);
      end
      e = n / P;
      if (e > NOPS - 1) e = NOPS - 1;
      check("op", alu_op, e);
      check("busy", busy, (n < LAST_E) ? 1 : 0);
      check("done", done, (n == LAST_E) ? 1 : 0);
      check("sig", signature, msig);
      check("hold_a", alu_a, a);
      check("hold_b", alu_b, b);
      check("rd", rd_data, mbuf[rd_addr]);
    end
    abort = 1'b0;
    if (hold) begin
      // DONE-cycle start was ignored; the following edge accepts a new sweep.
      next_a = 8'($urandom);
      a_in   = next_a;
      b_in   = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      check("rehold_busy", busy, 1);
      check("rehold_sig", signature, 0);
      check("rehold_a", alu_a, next_a);
      check("rehold_op", alu_op, 0);
    end
  endtask

  initial begin
    logic [7:0] na;
    logic [7:0] ra;
    logic [7:0] rb;
    int ab;
    int rs;
    for (int i = 0; i < NOPS; i++) mbuf[i] = 8'd0;
    msig = 8'd0;

    #2;
    check_all_zero("reset");
    check_buf("reset_rd");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Abort sampled at edge 10: ops 0..2 captured, rest untouched.
    run_sweep(8'd34, 8'd3, 10, 0, 0, 1'b0, 1'b0, na);
    tick();
    check_buf("abort_buf");

    // Full sweep with a start retry at edge 5 that must be ignored.
    run_sweep(8'd34, 8'd3, 0, 5, 0, 1'b0, 1'b0, na);
    check_buf("full_buf");
    check("full_buf15", mbuf[15], 49);

    // Reset during cycle 20, then a full sweep right after release.
    run_sweep(8'd34, 8'd3, 0, 0, 20, 1'b0, 1'b0, na);
    run_sweep(8'd34, 8'd3, 0, 0, 0, 1'b0, 1'b0, na);
    check_buf("post_rst_buf");

    // Start held through DONE, second sweep continues from the accepted edge.
    run_sweep(8'd200, 8'd7, 0, 0, 0, 1'b1, 1'b0, na);
    run_sweep(na, 8'd7, 0, 0, 0, 1'b0, 1'b1, na);
    check_buf("hold_buf");

    // Randomized sweeps; aborts past the last capture land in DONE and are ignored.
    for (int it = 0; it < 8; it++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ab = $urandom_range(0, LAST_E + 12);
      rs = $urandom_range(1, LAST_E + 1);
      run_sweep(ra, rb, ab, rs, 0, 1'b0, 1'b0, na);
      tick();
      check_buf("rand_buf");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sweep_ctrl.md
# alu_sweep_ctrl

Sequential controller that sits on the operand/opcode side of the 8-bit, 16-operation `top_alu`. It latches one operand pair and sweeps opcodes 0..15 through an external ALU instance. For each opcode it holds the inputs stable for a programmable settle time, then captures the ALU result into a 16-entry result buffer and folds it into a running signature. A readback port and a done pulse let a host or self-test harness collect all 16 results from one start command.

## Interface
- `NUM_OPS`, 16: opcodes swept, 0..NUM_OPS-1.
- `SETTLE`, 2: cycles inputs are held before capture. Must be ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `start`  in  1: begin a sweep. Sampled only in IDLE.
- `abort`  in  1: cancel a running sweep.
- `a_in`  in  8: operand A, latched on start acceptance.
- `b_in`  in  8: operand B, latched on start acceptance.
- `alu_a`  out  8: operand A to the ALU.
- `alu_b`  out  8: operand B to the ALU.
- `alu_op`  out  4: opcode to the ALU.
- `alu_out`  in  8: ALU result. Treated as combinational from `alu_a`/`alu_b`/`alu_op`.
- `busy`  out  1: high while the sweep runs (SETTLE/CAPTURE).
- `done`  out  1: one-cycle pulse after the last capture.
- `signature`  out  8: running signature of captured results.
- `rd_addr`  in  4: result buffer read address.
- `rd_data`  out  8: `buf[rd_addr]`, combinational read.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE:
  - On `start`=1: latch `alu_a<=a_in`, `alu_b<=b_in`, `alu_op<=0`, settle counter `cnt<=0`, `signature<=0`, then go to SETTLE.
- SETTLE:
  - `cnt` increments each cycle.
  - When `cnt==SETTLE-1`, go to CAPTURE.
- CAPTURE:
  - Write `buf[alu_op]<=alu_out`.
  - Update `signature<={signature[6:0],signature[7]}^alu_out` (rotate-left, then XOR).
  - If `alu_op==NUM_OPS-1`, go to DONE. Otherwise `alu_op<=alu_op+1`, `cnt<=0`, and go to SETTLE.
- DONE:
  - `done`=1 for this cycle only. `alu_op` stays at 15.
  - Return to IDLE.
- `start` is ignored in SETTLE, CAPTURE and DONE.
- `abort`=1 in SETTLE or CAPTURE: go to IDLE next edge.
  - Takes priority over a same-cycle capture, so no write happens.
  - No `done` pulse.
  - Buffer, `signature`, `alu_a`/`alu_b`/`alu_op` hold their values.
- `abort` is ignored in IDLE and DONE.
- Buffer contents persist across sweeps until overwritten. Only reset clears them.
- `rd_data` is readable at any time. A read of the address being written returns the old value until the edge.
- Opcode arithmetic is 4-bit unsigned. No wrap past NUM_OPS-1 occurs.

## Timing
- Reset (asynchronous, immediate): state IDLE; `alu_a`=`alu_b`=0, `alu_op`=0, `busy`=0, `done`=0, `signature`=0, all buffer entries 0, so `rd_data`=0.
- Reset mid-sweep aborts with no `done` pulse. After reset release, the first edge with `start`=1 is accepted.
- Let edge 0 be the edge that samples `start`. Then:
  - Per-op latency is SETTLE+1 cycles.
  - Capture of op k happens at edge (k+1)(SETTLE+1).
  - The `done` cycle follows edge NUM_OPS·(SETTLE+1).
  - With the defaults: captures at edges 3,6,…,48; `done` high in the cycle after edge 48; IDLE after edge 49.
- `busy` rises after edge 0 and falls after the last-capture edge (48 with defaults). It is low during DONE.
- `start` in the DONE cycle is ignored. The earliest new acceptance is the edge following the DONE cycle.

## Structure
- Package `alu_sweep_pkg`:
  - State enum (IDLE/SETTLE/CAPTURE/DONE).
  - Constants `DATA_W`=8, `OP_W`=4, `NUM_OPS`=16.
  - Signature-update function.
- Sub-module `alu_result_buf`: 16×8 register file with one synchronous write port, one asynchronous read port, and async active-low clear.
- Bench instantiates `alu_sweep_ctrl` plus either `top_alu` or a stub ALU with `out=a+{4'b0,op}`.

## Test plan
- Full sweep, stub ALU, `a_in`=34, `b_in`=3, SETTLE=2: `done` one cycle after edge 48; `buf[k]`=34+k (`buf[15]`=49); `signature` matches the bench model; `alu_op` stable for 3 cycles per value.
- Abort asserted for the edge-10 cycle: `busy` low after edge 10; no `done`; `buf[0..2]`=34,35,36; `buf[3..15]`=0.
- `start` re-asserted at edge 5 with `a_in`=1: ignored; `alu_a` stays 34; sweep completes normally.
- `rst_n` low during cycle 20: all outputs 0 immediately, `rd_data`=0 for every address; a new `start` after release runs a full sweep.
- `start` held high through DONE: no acceptance in the DONE cycle; a second sweep is accepted on the next edge and `signature` restarts from 0.
- Real `top_alu`, a=34, b=3: all 16 `rd_data` values equal the ALU outputs logged by the existing stimulus bench.
